// File: rtl/spi_req_pkg.sv
// Shared definitions for the SPI request bridge: response codes,
// FSM state encodings and read/write grant encodings.
package spi_req_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Request-handling FSM; the 3-bit encoding leaves illegal codes that
    // the FSM recovers from by returning to ST_IDLE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_EXEC = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_EXEC = 3'd3,
        ST_RD_RESP = 3'd4
    } state_e;

    // Side that won the most recent contested arbitration.
    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_e;

endpackage

// File: rtl/spi_start_ctrl.sv
// SPI transfer start control.
// Detects rising edges of the start control bit, issues a one-cycle start
// pulse to the SPI master and tracks the busy flag. A start edge that
// coincides with the done pulse is accepted (back-to-back transfers); a
// start edge while busy without done is dropped.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   start_bit_i      : start control bit (level)
//   trans_done_i     : SPI master done pulse
//   trans_start_o    : registered start pulse
//   spi_busy_o       : registered busy flag
module spi_start_ctrl (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic start_bit_i,
    input  logic trans_done_i,
    output logic trans_start_o,
    output logic spi_busy_o
);

    logic start_q;
    logic start_rise_c;
    logic trans_start_d;
    logic busy_d;

    // Next start pulse / busy flag
    always_comb begin
        start_rise_c  = start_bit_i & ~start_q;
        trans_start_d = 1'b0;
        busy_d        = spi_busy_o;
        if (start_rise_c && (!spi_busy_o || trans_done_i)) begin
            trans_start_d = 1'b1;
            busy_d        = 1'b1;
        end else if (trans_done_i) begin
            busy_d = 1'b0;
        end
    end

    // Edge-detect history and output registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            start_q       <= 1'b0;
            trans_start_o <= 1'b0;
            spi_busy_o    <= 1'b0;
        end else begin
            start_q       <= start_bit_i;
            trans_start_o <= trans_start_d;
            spi_busy_o    <= busy_d;
        end
    end

endmodule

// File: rtl/spi_req_bridge.sv
// SPI request bridge.
// Drains AXI-side write/read request FIFOs and routes each request to a
// register-file slot, the read-only status register, or the TX/RX data
// FIFOs, returning AXI-style response codes through the response FIFOs.
// Read and write requests are arbitrated round-robin when both are ready.
// Ports:
//   clk_i, reset_n_i                 : clock, asynchronous active-low reset
//   wr_req_* / wr_data_*             : write-request and write-data FIFOs
//   wr_resp_*                        : write-response FIFO
//   rd_req_* / rd_resp_*             : read-request and read-response FIFOs
//   reg_wr_* / reg_rd_*              : register-file write and read ports
//   tx_* / rx_*                      : TX and RX data FIFOs
//   start_bit_i, trans_done_i,
//   trans_start_o, spi_busy_o        : SPI transfer start control
// All outputs are registered except reg_rd_sel_o.
module spi_req_bridge
    import spi_req_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned NUM_REG = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           wr_req_empty_i,
    input  logic [SEL_W-1:0]               wr_req_sel_i,
    output logic                           wr_req_pull_o,
    input  logic                           wr_data_empty_i,
    input  logic [DATA_W+DATA_W/8-1:0]     wr_data_i,
    output logic                           wr_data_pull_o,
    input  logic                           wr_resp_full_i,
    output logic [1:0]                     wr_resp_data_o,
    output logic                           wr_resp_push_o,
    input  logic                           rd_req_empty_i,
    input  logic [SEL_W-1:0]               rd_req_sel_i,
    output logic                           rd_req_pull_o,
    input  logic                           rd_resp_full_i,
    output logic [DATA_W+1:0]              rd_resp_data_o,
    output logic                           rd_resp_push_o,
    output logic [SEL_W-1:0]               reg_wr_sel_o,
    output logic [DATA_W-1:0]              reg_wr_data_o,
    output logic [DATA_W/8-1:0]            reg_wr_strb_o,
    output logic                           reg_wr_load_o,
    output logic [SEL_W-1:0]               reg_rd_sel_o,
    input  logic [DATA_W-1:0]              reg_rd_data_i,
    input  logic                           tx_full_i,
    output logic [DATA_W-1:0]              tx_data_o,
    output logic                           tx_push_o,
    input  logic                           rx_empty_i,
    input  logic [DATA_W-1:0]              rx_data_i,
    output logic                           rx_pull_o,
    input  logic                           start_bit_i,
    input  logic                           trans_done_i,
    output logic                           trans_start_o,
    output logic                           spi_busy_o
);

    localparam int unsigned     STRB_W     = DATA_W / 8;
    localparam logic [SEL_W-1:0] STATUS_SEL = SEL_W'(NUM_REG);
    localparam logic [SEL_W-1:0] FIFO_SEL   = {SEL_W{1'b1}};

    state_e state_q, state_d;
    grant_e last_grant_q, last_grant_d;

    logic                 wr_ok_c;
    logic                 rd_ok_c;
    logic [DATA_W-1:0]    wr_wdata_c;
    logic [STRB_W-1:0]    wr_strb_c;

    logic                 wr_req_pull_d;
    logic                 wr_data_pull_d;
    logic [1:0]           wr_resp_data_d;
    logic                 wr_resp_push_d;
    logic                 rd_req_pull_d;
    logic [DATA_W+1:0]    rd_resp_data_d;
    logic                 rd_resp_push_d;
    logic [SEL_W-1:0]     reg_wr_sel_d;
    logic [DATA_W-1:0]    reg_wr_data_d;
    logic [STRB_W-1:0]    reg_wr_strb_d;
    logic                 reg_wr_load_d;
    logic [DATA_W-1:0]    tx_data_d;
    logic                 tx_push_d;
    logic                 rx_pull_d;

    // Register read index follows the read-request head directly
    assign reg_rd_sel_o = rd_req_sel_i;

    // Write-data FIFO head is packed as {data, strb}
    assign wr_wdata_c = wr_data_i[DATA_W+STRB_W-1:STRB_W];
    assign wr_strb_c  = wr_data_i[STRB_W-1:0];
    assign wr_ok_c    = !wr_req_empty_i && !wr_data_empty_i;
    assign rd_ok_c    = !rd_req_empty_i;

    // Next state, arbitration and next output-register values
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        wr_req_pull_d  = 1'b0;
        wr_data_pull_d = 1'b0;
        wr_resp_push_d = 1'b0;
        rd_req_pull_d  = 1'b0;
        rd_resp_push_d = 1'b0;
        reg_wr_load_d  = 1'b0;
        tx_push_d      = 1'b0;
        rx_pull_d      = 1'b0;
        wr_resp_data_d = wr_resp_data_o;
        rd_resp_data_d = rd_resp_data_o;
        reg_wr_sel_d   = reg_wr_sel_o;
        reg_wr_data_d  = reg_wr_data_o;
        reg_wr_strb_d  = reg_wr_strb_o;
        tx_data_d      = tx_data_o;

        case (state_q)
            ST_IDLE: begin
                if (wr_ok_c && rd_ok_c) begin
                    // Contested: grant the side that did not win last time
                    if (last_grant_q == GRANT_READ) begin
                        state_d      = ST_WR_EXEC;
                        last_grant_d = GRANT_WRITE;
                    end else begin
                        state_d      = ST_RD_EXEC;
                        last_grant_d = GRANT_READ;
                    end
                end else if (wr_ok_c) begin
                    state_d = ST_WR_EXEC;
                end else if (rd_ok_c) begin
                    state_d = ST_RD_EXEC;
                end
            end

            ST_WR_EXEC: begin
                wr_req_pull_d  = 1'b1;
                wr_data_pull_d = 1'b1;
                state_d        = ST_WR_RESP;
                if (wr_req_sel_i < STATUS_SEL) begin
                    reg_wr_load_d  = 1'b1;
                    reg_wr_sel_d   = wr_req_sel_i;
                    reg_wr_data_d  = wr_wdata_c;
                    reg_wr_strb_d  = wr_strb_c;
                    wr_resp_data_d = RESP_OKAY;
                end else if ((wr_req_sel_i == FIFO_SEL) && (&wr_strb_c) && !tx_full_i) begin
                    tx_push_d      = 1'b1;
                    tx_data_d      = wr_wdata_c;
                    wr_resp_data_d = RESP_OKAY;
                end else begin
                    // Status register, undefined index, partial strobe or TX full
                    wr_resp_data_d = RESP_SLVERR;
                end
            end

            ST_WR_RESP: begin
                if (!wr_resp_full_i) begin
                    wr_resp_push_d = 1'b1;
                    state_d        = ST_IDLE;
                end
            end

            ST_RD_EXEC: begin
                rd_req_pull_d = 1'b1;
                state_d       = ST_RD_RESP;
                if (rd_req_sel_i <= STATUS_SEL) begin
                    rd_resp_data_d = {reg_rd_data_i, RESP_OKAY};
                end else if ((rd_req_sel_i == FIFO_SEL) && !rx_empty_i) begin
                    rd_resp_data_d = {rx_data_i, RESP_OKAY};
                    rx_pull_d      = 1'b1;
                end else begin
                    rd_resp_data_d = {{DATA_W{1'b1}}, RESP_SLVERR};
                end
            end

            ST_RD_RESP: begin
                if (!rd_resp_full_i) begin
                    rd_resp_push_d = 1'b1;
                    state_d        = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, arbitration history and output registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= GRANT_READ;
            wr_req_pull_o  <= 1'b0;
            wr_data_pull_o <= 1'b0;
            wr_resp_data_o <= 2'b00;
            wr_resp_push_o <= 1'b0;
            rd_req_pull_o  <= 1'b0;
            rd_resp_data_o <= '0;
            rd_resp_push_o <= 1'b0;
            reg_wr_sel_o   <= '0;
            reg_wr_data_o  <= '0;
            reg_wr_strb_o  <= '0;
            reg_wr_load_o  <= 1'b0;
            tx_data_o      <= '0;
            tx_push_o      <= 1'b0;
            rx_pull_o      <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            wr_req_pull_o  <= wr_req_pull_d;
            wr_data_pull_o <= wr_data_pull_d;
            wr_resp_data_o <= wr_resp_data_d;
            wr_resp_push_o <= wr_resp_push_d;
            rd_req_pull_o  <= rd_req_pull_d;
            rd_resp_data_o <= rd_resp_data_d;
            rd_resp_push_o <= rd_resp_push_d;
            reg_wr_sel_o   <= reg_wr_sel_d;
            reg_wr_data_o  <= reg_wr_data_d;
            reg_wr_strb_o  <= reg_wr_strb_d;
            reg_wr_load_o  <= reg_wr_load_d;
            tx_data_o      <= tx_data_d;
            tx_push_o      <= tx_push_d;
            rx_pull_o      <= rx_pull_d;
        end
    end

    // Transfer start / busy tracking
    spi_start_ctrl u_start_ctrl (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .start_bit_i   (start_bit_i),
        .trans_done_i  (trans_done_i),
        .trans_start_o (trans_start_o),
        .spi_busy_o    (spi_busy_o)
    );

endmodule

// File: tb/tb_spi_req_bridge.sv
// Directed self-checking bench for spi_req_bridge (default parameters).
module tb_spi_req_bridge;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        wr_req_empty_i;
    logic [1:0]  wr_req_sel_i;
    logic        wr_req_pull_o;
    logic        wr_data_empty_i;
    logic [35:0] wr_data_i;
    logic        wr_data_pull_o;
    logic        wr_resp_full_i;
    logic [1:0]  wr_resp_data_o;
    logic        wr_resp_push_o;
    logic        rd_req_empty_i;
    logic [1:0]  rd_req_sel_i;
    logic        rd_req_pull_o;
    logic        rd_resp_full_i;
    logic [33:0] rd_resp_data_o;
    logic        rd_resp_push_o;
    logic [1:0]  reg_wr_sel_o;
    logic [31:0] reg_wr_data_o;
    logic [3:0]  reg_wr_strb_o;
    logic        reg_wr_load_o;
    logic [1:0]  reg_rd_sel_o;
    logic [31:0] reg_rd_data_i;
    logic        tx_full_i;
    logic [31:0] tx_data_o;
    logic        tx_push_o;
    logic        rx_empty_i;
    logic [31:0] rx_data_i;
    logic        rx_pull_o;
    logic        start_bit_i;
    logic        trans_done_i;
    logic        trans_start_o;
    logic        spi_busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Request FIFO models (show-ahead heads, popped on DUT pull pulses)
    logic [1:0]  wq_sel [8];
    logic [35:0] wq_dat [8];
    logic [3:0]  wq_head = '0;
    logic [3:0]  wq_tail = '0;
    logic [1:0]  rq_sel [8];
    logic [3:0]  rq_head = '0;
    logic [3:0]  rq_tail = '0;

    assign wr_req_empty_i  = (wq_head == wq_tail);
    assign wr_data_empty_i = (wq_head == wq_tail);
    assign wr_req_sel_i    = wq_sel[wq_head[2:0]];
    assign wr_data_i       = wq_dat[wq_head[2:0]];
    assign rd_req_empty_i  = (rq_head == rq_tail);
    assign rd_req_sel_i    = rq_sel[rq_head[2:0]];

    always @(posedge clk_i) begin
        if (wr_req_pull_o) wq_head <= wq_head + 4'd1;
        if (rd_req_pull_o) rq_head <= rq_head + 4'd1;
    end

    // Grant log: 0 = write, 1 = read
    logic       log_en = 1'b0;
    logic [7:0] glog   = '0;
    int         log_n  = 0;
    always @(posedge clk_i) begin
        if (log_en && wr_req_pull_o) begin
            glog[log_n[2:0]] <= 1'b0;
            log_n <= log_n + 1;
        end else if (log_en && rd_req_pull_o) begin
            glog[log_n[2:0]] <= 1'b1;
            log_n <= log_n + 1;
        end
    end

    always #5 clk_i = ~clk_i;

    spi_req_bridge dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .wr_req_empty_i  (wr_req_empty_i),
        .wr_req_sel_i    (wr_req_sel_i),
        .wr_req_pull_o   (wr_req_pull_o),
        .wr_data_empty_i (wr_data_empty_i),
        .wr_data_i       (wr_data_i),
        .wr_data_pull_o  (wr_data_pull_o),
        .wr_resp_full_i  (wr_resp_full_i),
        .wr_resp_data_o  (wr_resp_data_o),
        .wr_resp_push_o  (wr_resp_push_o),
        .rd_req_empty_i  (rd_req_empty_i),
        .rd_req_sel_i    (rd_req_sel_i),
        .rd_req_pull_o   (rd_req_pull_o),
        .rd_resp_full_i  (rd_resp_full_i),
        .rd_resp_data_o  (rd_resp_data_o),
        .rd_resp_push_o  (rd_resp_push_o),
        .reg_wr_sel_o    (reg_wr_sel_o),
        .reg_wr_data_o   (reg_wr_data_o),
        .reg_wr_strb_o   (reg_wr_strb_o),
        .reg_wr_load_o   (reg_wr_load_o),
        .reg_rd_sel_o    (reg_rd_sel_o),
        .reg_rd_data_i   (reg_rd_data_i),
        .tx_full_i       (tx_full_i),
        .tx_data_o       (tx_data_o),
        .tx_push_o       (tx_push_o),
        .rx_empty_i      (rx_empty_i),
        .rx_data_i       (rx_data_i),
        .rx_pull_o       (rx_pull_o),
        .start_bit_i     (start_bit_i),
        .trans_done_i    (trans_done_i),
        .trans_start_o   (trans_start_o),
        .spi_busy_o      (spi_busy_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic pick(input int which);
        return (which == 0) ? wr_req_pull_o : rd_req_pull_o;
    endfunction

    // Wait (bounded) for a write (0) or read (1) pull pulse, sampled at negedge
    task automatic wait_for(input int which, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_i);
            seen = pick(which);
        end
        if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic push_wr(input logic [1:0] sel, input logic [31:0] d, input logic [3:0] s);
        wq_sel[wq_tail[2:0]] = sel;
        wq_dat[wq_tail[2:0]] = {d, s};
        wq_tail = wq_tail + 4'd1;
    endtask

    task automatic push_rd(input logic [1:0] sel);
        rq_sel[rq_tail[2:0]] = sel;
        rq_tail = rq_tail + 4'd1;
    endtask

    task automatic do_write(input string tag, input logic [1:0] sel, input logic [31:0] d,
                            input logic [3:0] s, input logic exp_load, input logic exp_push,
                            input logic [1:0] exp_resp);
        push_wr(sel, d, s);
        wait_for(0, tag);
        check({tag, "_load"}, 64'(reg_wr_load_o), 64'(exp_load));
        check({tag, "_txpush"}, 64'(tx_push_o), 64'(exp_push));
        check({tag, "_dpull"}, 64'(wr_data_pull_o), 64'd1);
        @(negedge clk_i);
        check({tag, "_rpush"}, 64'(wr_resp_push_o), 64'd1);
        check({tag, "_resp"}, 64'(wr_resp_data_o), 64'(exp_resp));
        check({tag, "_pulse1"}, 64'({reg_wr_load_o, tx_push_o, wr_req_pull_o}), 64'd0);
    endtask

    task automatic finish_read(input string tag, input logic [1:0] sel,
                               input logic [33:0] exp_data, input logic exp_rx);
        wait_for(1, tag);
        check({tag, "_rdsel"}, 64'(reg_rd_sel_o), 64'(sel));
        check({tag, "_rxpull"}, 64'(rx_pull_o), 64'(exp_rx));
        @(negedge clk_i);
        check({tag, "_rpush"}, 64'(rd_resp_push_o), 64'd1);
        check({tag, "_data"}, 64'(rd_resp_data_o), 64'(exp_data));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulses"}, 64'({wr_req_pull_o, wr_data_pull_o, wr_resp_push_o, rd_req_pull_o,
                                     rd_resp_push_o, reg_wr_load_o, tx_push_o, rx_pull_o,
                                     trans_start_o, spi_busy_o}), 64'd0);
        check({tag, "_data"}, 64'(|{wr_resp_data_o, rd_resp_data_o, reg_wr_sel_o, reg_wr_data_o,
                                    reg_wr_strb_o, tx_data_o}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            wq_sel[i] = '0;
            wq_dat[i] = '0;
            rq_sel[i] = '0;
        end
        reset_n_i      = 1'b0;
        wr_resp_full_i = 1'b0;
        rd_resp_full_i = 1'b0;
        reg_rd_data_i  = 32'h0000_0011;
        tx_full_i      = 1'b0;
        rx_empty_i     = 1'b1;
        rx_data_i      = 32'hDEAD_BEEF;
        start_bit_i    = 1'b0;
        trans_done_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        reset_n_i = 1'b1;
        @(negedge clk_i);

        // Register write and its latched payload
        do_write("wr_reg1", 2'd1, 32'hA5A5_0F0F, 4'hF, 1'b1, 1'b0, 2'b00);
        check("wr_reg1_sel", 64'(reg_wr_sel_o), 64'd1);
        check("wr_reg1_wdata", 64'(reg_wr_data_o), 64'hA5A5_0F0F);
        check("wr_reg1_strb", 64'(reg_wr_strb_o), 64'hF);

        // FIFO writes rejected: TX full, then partial strobe
        tx_full_i = 1'b1;
        do_write("wr_fifo_full", 2'd3, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 2'b10);
        tx_full_i = 1'b0;
        do_write("wr_fifo_part", 2'd3, 32'h1234_5678, 4'h3, 1'b0, 1'b0, 2'b10);
        // FIFO write accepted
        do_write("wr_fifo_ok", 2'd3, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1, 2'b00);
        check("wr_fifo_ok_txdata", 64'(tx_data_o), 64'hCAFE_F00D);
        // Status register write: SLVERR, register payload untouched
        do_write("wr_status", 2'd2, 32'h5555_5555, 4'hF, 1'b0, 1'b0, 2'b10);
        check("wr_status_keep", 64'(reg_wr_data_o), 64'hA5A5_0F0F);

        // Reads
        push_rd(2'd3);
        finish_read("rd_rx_empty", 2'd3, {32'hFFFF_FFFF, 2'b10}, 1'b0);
        push_rd(2'd2);
        finish_read("rd_status", 2'd2, {32'h0000_0011, 2'b00}, 1'b0);
        rx_empty_i = 1'b0;
        push_rd(2'd3);
        finish_read("rd_rx_ok", 2'd3, {32'hDEAD_BEEF, 2'b00}, 1'b1);
        rx_empty_i = 1'b1;
        reg_rd_data_i = 32'h0BAD_CAFE;
        push_rd(2'd0);
        finish_read("rd_reg0", 2'd0, {32'h0BAD_CAFE, 2'b00}, 1'b0);

        // Round-robin arbitration from reset: both queues stay non-empty
        reset_n_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        log_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_wr(2'd0, 32'h1000_0000 + 32'(i), 4'hF);
            push_rd(2'd1);
        end
        for (int i = 0; i < 200 && log_n < 6; i++) @(negedge clk_i);
        repeat (4) @(negedge clk_i);
        log_en = 1'b0;
        check("arb_count", 64'(log_n), 64'd6);
        check("arb_order", 64'(glog[5:0]), 64'b101010);

        // Write response back-pressure
        wr_resp_full_i = 1'b1;
        push_wr(2'd0, 32'h7777_0000, 4'hF);
        wait_for(0, "hold");
        push_rd(2'd2);
        reg_rd_data_i = 32'h0000_0042;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check($sformatf("hold_nopush%0d", i), 64'(wr_resp_push_o), 64'd0);
            check($sformatf("hold_nogrant%0d", i), 64'(rd_req_pull_o), 64'd0);
        end
        wr_resp_full_i = 1'b0;
        @(negedge clk_i);
        check("hold_push", 64'(wr_resp_push_o), 64'd1);
        check("hold_resp", 64'(wr_resp_data_o), 64'd0);
        finish_read("hold_rd", 2'd2, {32'h0000_0042, 2'b00}, 1'b0);

        // Start control
        @(negedge clk_i);
        start_bit_i = 1'b1;
        @(negedge clk_i);
        check("start1_pulse", 64'(trans_start_o), 64'd1);
        check("start1_busy", 64'(spi_busy_o), 64'd1);
        @(negedge clk_i);
        check("start1_width", 64'(trans_start_o), 64'd0);
        start_bit_i = 1'b0;
        @(negedge clk_i);
        start_bit_i = 1'b1;
        @(negedge clk_i);
        check("start_busy_drop", 64'(trans_start_o), 64'd0);
        check("start_busy_keep", 64'(spi_busy_o), 64'd1);
        start_bit_i = 1'b0;
        @(negedge clk_i);
        start_bit_i  = 1'b1;
        trans_done_i = 1'b1;
        @(negedge clk_i);
        trans_done_i = 1'b0;
        check("start_coll_pulse", 64'(trans_start_o), 64'd1);
        check("start_coll_busy", 64'(spi_busy_o), 64'd1);
        trans_done_i = 1'b1;
        @(negedge clk_i);
        trans_done_i = 1'b0;
        check("done_clear_busy", 64'(spi_busy_o), 64'd0);
        check("done_no_pulse", 64'(trans_start_o), 64'd0);

        // Reset asserted while the write response is held
        start_bit_i = 1'b0;
        @(negedge clk_i);
        start_bit_i = 1'b1;
        @(negedge clk_i);
        check("pre_rst_busy", 64'(spi_busy_o), 64'd1);
        wr_resp_full_i = 1'b1;
        push_wr(2'd1, 32'h0F0F_F0F0, 4'hC);
        wait_for(0, "rst_mid");
        @(negedge clk_i);
        reset_n_i = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk_i);
        wr_resp_full_i = 1'b0;
        start_bit_i    = 1'b0;
        reset_n_i      = 1'b1;
        @(negedge clk_i);
        check("rst_after_nopush", 64'(wr_resp_push_o), 64'd0);
        do_write("wr_after_rst", 2'd0, 32'h0000_00AA, 4'h1, 1'b1, 1'b0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
